// File: rtl/stall_request_unit.sv
// MMIO front-end that queues stall lengths and hands them one at a time to a
// downstream stall generator, tracking completions, overflow and missing-stall errors.
module stall_request_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_stall,
  output logic        o_stall_gen,
  output logic [12:0] o_stall_count,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [12:0]   r_fifo [DEPTH];
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [12:0]   r_len;
  logic [7:0]    r_done_cnt;
  logic          r_err;
  logic          r_ovf;
  logic          r_rvalid;
  logic [31:0]   r_rdata;

  logic          w_hit;
  logic          w_sel_status;
  logic          w_push_req;
  logic          w_status_wr;
  logic          w_rd;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_count_ext;
  logic [2:0]    w_count_sat;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_err_set;
  logic          w_done;
  logic          w_busy;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  // Only the 8-byte window matters; bit 2 picks STATUS over CMD.
  assign w_hit        = i_mem_req && (i_mem_addr[31:3] == BASE_ADDR[31:3]);
  assign w_sel_status = i_mem_addr[2];
  assign w_push_req   = w_hit && i_mem_we && !w_sel_status && i_mem_wdata[31];
  assign w_status_wr  = w_hit && i_mem_we && w_sel_status;
  assign w_rd         = w_hit && !i_mem_we;

  assign w_fifo_count = r_wr_ptr - r_rd_ptr;
  assign w_count_ext  = 32'(w_fifo_count);
  assign w_count_sat  = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];
  assign w_empty      = (w_fifo_count == '0);
  assign w_full       = (w_fifo_count == FULL_CNT);

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovf_set = w_push_req && w_full && !w_pop;
  assign w_err_set = (r_state == S_WAIT_START) && !i_stall;
  assign w_done    = (r_state == S_WAIT_DONE) && !i_stall;
  assign w_busy    = (r_state != S_IDLE) || !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (!w_empty) w_state_nxt = S_ISSUE;
      S_ISSUE:      w_state_nxt = S_WAIT_START;
      S_WAIT_START: w_state_nxt = i_stall ? S_WAIT_DONE : S_IDLE;
      S_WAIT_DONE:  if (!i_stall) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage array needs no reset: the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= i_mem_wdata[12:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_len    <= r_fifo[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      r_err <= w_err_set || (r_err && !(w_status_wr && i_mem_wdata[2]));
      r_ovf <= w_ovf_set || (r_ovf && !(w_status_wr && i_mem_wdata[1]));
      if (w_done) begin
        r_done_cnt <= r_done_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_rd_data = {19'b0, r_len};
    if (w_sel_status) begin
      w_rd_data = {16'b0, r_done_cnt, 2'b0, w_count_sat, r_err, r_ovf, w_busy};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign o_stall_gen   = (r_state == S_ISSUE);
  assign o_stall_count = r_len;
  assign o_rvalid      = r_rvalid;
  assign o_rdata       = r_rdata;
  assign o_busy        = w_busy;
  assign o_dbg_state   = r_state;

  assign w_unused = ^{i_mem_addr[1:0], i_mem_wdata[30:13]};

endmodule

// File: tb/tb_stall_request_unit.sv
// Directed bench for stall_request_unit: a stall-generator model answers each
// pulse, and a scoreboard of queued lengths checks issue order and count.
module tb_stall_request_unit;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] A_CMD    = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WDONE = 2'd3;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic        i_stall;
  logic        o_stall_gen;
  logic [12:0] o_stall_count;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int stall_left = 0;
  int model_len = 8;
  bit model_on = 1'b1;
  bit gen_seen = 1'b0;
  bit have_last = 1'b0;
  bit prev_gen = 1'b0;
  bit dbl_pulse = 1'b0;
  logic [12:0] exp_q[$];

  stall_request_unit #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_mem_req    (i_mem_req),
    .i_mem_we     (i_mem_we),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_stall      (i_stall),
    .o_stall_gen  (o_stall_gen),
    .o_stall_count(o_stall_count),
    .o_rvalid     (o_rvalid),
    .o_rdata      (o_rdata),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and cycle counter
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Stall-generator model: i_stall rises the cycle after a pulse, holds model_len cycles.
  initial begin
    i_stall = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        stall_left = 0;
        gen_seen = 1'b0;
      end else if (gen_seen) begin
        stall_left = model_len;
        gen_seen = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      i_stall = model_on && (stall_left > 0);
    end
  end

  // Pulse monitor and scoreboard
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_stall_gen === 1'b1) begin
        if (prev_gen) dbl_pulse = 1'b1;
        pulse_cnt++;
        if (have_last) check("pulse_gap", 32'(cyc - last_pulse_cyc >= 3), 32'd1);
        have_last = 1'b1;
        last_pulse_cyc = cyc;
        gen_seen = 1'b1;
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_len", 32'(o_stall_count), 32'(exp_q.pop_front()));
      end
      prev_gen = (o_stall_gen === 1'b1);
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    i_mem_req = 1'b1;
    i_mem_we = 1'b1;
    i_mem_addr = addr;
    i_mem_wdata = data;
    tick();
    i_mem_req = 1'b0;
    i_mem_we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    logic rv1;
    logic rv2;
    i_mem_req = 1'b1;
    i_mem_we = 1'b0;
    i_mem_addr = addr;
    tick();
    i_mem_req = 1'b0;
    rv1 = o_rvalid;
    data = o_rdata;
    tick();
    rv2 = o_rvalid;
    check("rvalid_hi", 32'(rv1), 32'd1);
    check("rvalid_lo", 32'(rv2), 32'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (o_busy === 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic wait_pulse(input int base, input int max_cyc);
    int n = 0;
    while (pulse_cnt <= base && n < max_cyc) begin
      tick();
      n++;
    end
    check("pulse_timeout", 32'(pulse_cnt > base), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gen"},   32'(o_stall_gen), 32'd0);
    check({tag, "_count"}, 32'(o_stall_count), 32'd0);
    check({tag, "_rvalid"}, 32'(o_rvalid), 32'd0);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    int wc;
    logic [31:0] wd;
    i_rst_n = 1'b0;
    i_mem_req = 1'b0;
    i_mem_we = 1'b0;
    i_mem_addr = '0;
    i_mem_wdata = '0;
    repeat (2) tick();
    check_all_zero("rst");
    i_rst_n = 1'b1;
    tick();

    // Single command: pulse two cycles after the write, count 3
    base = pulse_cnt;
    exp_q.push_back(13'd3);
    wc = cyc;
    bus_write(A_CMD, 32'h8000_0003);
    check("t1_busy", 32'(o_busy), 32'd1);
    wait_idle(100);
    check("t1_pulses", 32'(pulse_cnt - base), 32'd1);
    check("t1_latency", 32'(last_pulse_cyc), 32'(wc + 2));
    check("t1_count_hold", 32'(o_stall_count), 32'd3);
    bus_read(A_STATUS, rd);
    check("t1_status", rd, 32'h0000_0100);
    bus_read(A_CMD, rd);
    check("t1_cmd_rd", rd, 32'h0000_0003);

    // Writes that must be ignored
    base = pulse_cnt;
    bus_write(A_CMD, 32'h0000_0005);
    bus_write(BASE + 32'h8, 32'h8000_0007);
    bus_write(32'h2000_0000, 32'h8000_0009);
    repeat (6) tick();
    check("ign_pulses", 32'(pulse_cnt - base), 32'd0);
    check("ign_busy", 32'(o_busy), 32'd0);
    i_mem_req = 1'b1;
    i_mem_we = 1'b0;
    i_mem_addr = BASE + 32'h8;
    tick();
    i_mem_req = 1'b0;
    check("nohit_rvalid", 32'(o_rvalid), 32'd0);

    // Overflow: five writes while the first command is stalling
    base = pulse_cnt;
    exp_q.push_back(13'h00A);
    bus_write(A_CMD, 32'h8000_000A);
    wait_pulse(base, 20);
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(13'(13'h11 + i));
      bus_write(A_CMD, 32'h8000_0011 + 32'(i));
    end
    bus_read(A_STATUS, rd);
    check("t2_status_ovf", rd, 32'h0000_0123);
    bus_write(A_STATUS, 32'h0000_0002);
    bus_read(A_STATUS, rd);
    check("t2_status_clr", rd, 32'h0000_0121);
    wait_idle(300);
    check("t2_pulses", 32'(pulse_cnt - base), 32'd4);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    bus_read(A_STATUS, rd);
    check("t2_status_end", rd, 32'h0000_0600);

    // Missing stall: ERR set (winning over a same-cycle clear), next command still issued
    model_on = 1'b0;
    base = pulse_cnt;
    exp_q.push_back(13'h021);
    exp_q.push_back(13'h022);
    bus_write(A_CMD, 32'h8000_0021);
    bus_write(A_CMD, 32'h8000_0022);
    wait_pulse(base, 20);
    bus_write(A_STATUS, 32'h0000_0004);
    check("t3_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    bus_read(A_STATUS, rd);
    check("t3_status_err", rd, 32'h0000_060D);
    wait_idle(100);
    check("t3_pulses", 32'(pulse_cnt - base), 32'd2);
    bus_read(A_STATUS, rd);
    check("t3_status_end", rd, 32'h0000_0604);
    bus_write(A_STATUS, 32'h0000_0004);
    bus_read(A_STATUS, rd);
    check("t3_err_clr", rd, 32'h0000_0600);
    model_on = 1'b1;

    // DONE_CNT wrap after 256 completions in total
    model_len = 1;
    for (int i = 0; i < 249; i++) begin
      wd = (i == 0) ? 32'hFFFF_FFFF : (32'h8000_0000 | 32'(i));
      exp_q.push_back((i == 0) ? 13'h1FFF : 13'(i));
      bus_write(A_CMD, wd);
      wait_idle(40);
    end
    bus_read(A_STATUS, rd);
    check("t4_done_255", rd, 32'h0000_FF00);
    exp_q.push_back(13'd249);
    bus_write(A_CMD, 32'h8000_00F9);
    wait_idle(40);
    bus_read(A_STATUS, rd);
    check("t4_done_wrap", rd, 32'h0000_0000);
    bus_read(A_CMD, rd);
    check("t4_cmd_rd", rd, 32'h0000_00F9);

    // Push into a full FIFO in the same cycle as an IDLE pop
    model_len = 8;
    base = pulse_cnt;
    exp_q.push_back(13'h031);
    bus_write(A_CMD, 32'h8000_0031);
    wait_pulse(base, 20);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(13'(13'h32 + i));
      bus_write(A_CMD, 32'h8000_0032 + 32'(i));
    end
    for (int n = 0; n < 30 && o_dbg_state !== ST_IDLE; n++) tick();
    check("t5_idle_reached", 32'(o_dbg_state), 32'(ST_IDLE));
    exp_q.push_back(13'h036);
    bus_write(A_CMD, 32'h8000_0036);
    bus_read(A_STATUS, rd);
    check("t5_ovf", 32'(rd[1]), 32'd0);
    check("t5_fifo_count", 32'(rd[5:3]), 32'd4);
    check("t5_status", rd, 32'h0000_0121);
    wait_idle(400);
    check("t5_pulses", 32'(pulse_cnt - base), 32'd6);
    bus_read(A_STATUS, rd);
    check("t5_status_end", rd, 32'h0000_0600);

    // Reset during WAIT_DONE with two commands queued
    base = pulse_cnt;
    exp_q.push_back(13'h041);
    bus_write(A_CMD, 32'h8000_0041);
    wait_pulse(base, 20);
    bus_write(A_CMD, 32'h8000_0042);
    bus_write(A_CMD, 32'h8000_0043);
    bus_read(A_STATUS, rd);
    check("t6_status_pre", rd, 32'h0000_0611);
    check("t6_in_wait_done", 32'(o_dbg_state), 32'(ST_WDONE));
    base = pulse_cnt;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (30) tick();
    check("t6_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("t6_busy", 32'(o_busy), 32'd0);
    bus_read(A_STATUS, rd);
    check("t6_status", rd, 32'h0000_0000);
    bus_read(A_CMD, rd);
    check("t6_cmd_rd", rd, 32'h0000_0000);

    check("single_cycle_pulse", 32'(dbl_pulse), 32'd0);
    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stall_request_unit.md
STALL_REQUEST_UNIT -- requirements
Module: stall_request_unit

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, base of the 8-byte MMIO window.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-003 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_mem_req, input, 1, core data-bus request valid.
REQ-006 SHALL have port i_mem_we, input, 1, 1=write, 0=read.
REQ-007 SHALL have port i_mem_addr, input, 32, byte address.
REQ-008 SHALL have port i_mem_wdata, input, 32, write data.
REQ-009 SHALL have port i_stall, input, 1, stall level fed back from the downstream stall generator.
REQ-010 SHALL have port o_stall_gen, output, 1, one-cycle start pulse to the stall generator.
REQ-011 SHALL have port o_stall_count, output, 13, length for the stall generator, valid when o_stall_gen=1.
REQ-012 SHALL have port o_rvalid, output, 1, read data valid.
REQ-013 SHALL have port o_rdata, output, 32, read data.
REQ-014 SHALL have port o_busy, output, 1, FSM not IDLE or FIFO not empty.

Function
REQ-015 SHALL decode a hit when i_mem_req=1 and i_mem_addr[31:3]==BASE_ADDR[31:3]; offset 0x0=CMD, 0x4=STATUS; non-hits ignored.
REQ-016 SHALL, on a CMD write with wdata[31]=1, push wdata[12:0] into the FIFO; a CMD write with wdata[31]=0 has no effect.
REQ-017 SHALL accept the push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 SHALL, on a push to a full FIFO with no same-cycle pop, drop the command and set sticky flag OVF.
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> IDLE.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head entry into a length register and go to ISSUE.
REQ-021 SHALL, in ISSUE, drive o_stall_gen=1 for exactly one cycle with o_stall_count equal to the length register, then go to WAIT_START.
REQ-022 SHALL, in WAIT_START, go to WAIT_DONE if i_stall=1; otherwise set sticky flag ERR and go to IDLE.
REQ-023 SHALL, in WAIT_DONE, stay while i_stall=1; on i_stall=0, increment the 8-bit DONE_CNT (wraps 255->0) and go to IDLE.
REQ-024 SHALL drive o_stall_gen=0 in all states other than ISSUE.
REQ-025 SHALL hold o_stall_count at the last issued length between pulses.
REQ-026 SHALL, on any hit read, assert o_rvalid on the following cycle for exactly one cycle, with o_rdata registered.
REQ-027 SHALL return CMD reads as {19'b0, length register}.
REQ-028 SHALL return STATUS reads as {16'b0, DONE_CNT[7:0], 2'b0, fifo_count[2:0], ERR, OVF, o_busy}; fifo_count saturates at 7.
REQ-029 SHALL, on a STATUS write, clear OVF if wdata[1]=1 and ERR if wdata[2]=1 (write-1-to-clear).
REQ-030 SHALL let a same-cycle set win over a same-cycle clear for ERR and OVF.
REQ-031 SHALL give a command pushed while the FSM is in IDLE with an empty FIFO its o_stall_gen pulse two cycles after the write cycle (push, pop, issue).
REQ-032 SHALL issue commands in FIFO order, with at least one IDLE cycle between consecutive pulses.

Reset
REQ-033 SHALL, while i_rst_n=0, force FSM=IDLE, FIFO empty, length register=0, DONE_CNT=0, ERR=0, OVF=0, o_stall_gen=0, o_stall_count=0, o_rvalid=0, o_rdata=0, o_busy=0.
REQ-034 SHALL, on reset mid-operation, discard all queued and in-flight commands without further pulses.

Verification
REQ-035 SHALL cover single command: CMD write 32'h8000_0003 with a stall-generator model -> pulse 2 cycles later with count=3; i_stall high 8 cycles; DONE_CNT=1; o_busy=0 afterwards.
REQ-036 SHALL cover overflow: 5 back-to-back CMD writes (DEPTH=4) while the first is stalling -> 4 pulses total; STATUS reads OVF=1; writing 32'h2 to STATUS clears OVF.
REQ-037 SHALL cover the missing-stall error: hold i_stall=0 -> ERR=1 after the pulse, FSM back in IDLE, next queued command still issued.
REQ-038 SHALL cover readback: STATUS read while idle after 256 completions -> o_rvalid one cycle later; DONE_CNT=0; busy=0.
REQ-039 SHALL cover reset mid-run: assert i_rst_n=0 during WAIT_DONE with 2 entries queued -> all outputs 0 and no pulse after release.
REQ-040 SHALL cover the full-FIFO boundary: push while full in the same cycle as an IDLE pop -> push accepted, OVF stays 0, fifo_count stays 4.
